// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end
// (fetch_queue and its fetch_fifo buffer).
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package fetch_pkg;

    localparam int DATA_W = `DATA_SIZE;

    localparam logic [DATA_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [31:0]       pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {inst, pc} pairs with a registered
// head entry, so the consumer never sees a combinational path from push data.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               din,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output fetch_entry_t               head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
    localparam logic [CW-1:0] COUNT_ONE = CW'(1'b1);

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    fetch_entry_t  head_r;

    logic          push_ok_s;
    logic          pop_ok_s;
    logic [PW-1:0] rd_next_s;
    logic [CW-1:0] count_next_s;
    fetch_entry_t  head_next_s;

    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == '0);
    assign count = count_r;
    assign head  = head_r;

    // Accept/advance decisions and the entry that will sit at the head next cycle.
    always_comb begin
        pop_ok_s     = pop && !empty;
        push_ok_s    = push && (!full || pop_ok_s);
        rd_next_s    = rd_ptr_r;
        count_next_s = count_r;
        head_next_s  = mem_r[rd_ptr_r];
        if (pop_ok_s) begin
            rd_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_next_s = rd_ptr_r;
        end
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + COUNT_ONE;
        end else if (pop_ok_s && !push_ok_s) begin
            count_next_s = count_r - COUNT_ONE;
        end else begin
            count_next_s = count_r;
        end
        // A word written into the slot that becomes the head bypasses the array.
        if (push_ok_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = din;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Storage array, pointers, occupancy and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{inst: NOP_INST, pc: 32'h0000_0000};
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '{inst: NOP_INST, pc: 32'h0000_0000};
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            if (count_next_s != '0) begin
                head_r <= head_next_s;
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: sequential PC generation, req/gnt fetch with one
// outstanding request, buffered delivery to decode, and redirect flush.
// Optional build macro FETCH_MISALIGN_CHK_EN enables the misaligned-redirect flag.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        fetch_misalign
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] DEPTH_W = CW1'(DEPTH);

    fetch_state_e  state_r;
    fetch_state_e  state_next_s;
    logic          run_s;

    logic [31:0]   fetch_pc_r;
    logic [31:0]   req_pc_r;
    logic          outstanding_r;
    logic          discard_r;

    logic          req_s;
    logic          granted_s;
    logic          rvalid_ok_s;
    logic          push_s;
    logic          pop_s;
    logic [CW:0]   used_s;
    logic [CW:0]   limit_s;
    logic [31:0]   pc_next_s;
    logic [31:0]   req_pc_next_s;
    logic          out_next_s;
    logic          disc_next_s;

    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    fetch_entry_t  fifo_head_s;
    fetch_entry_t  fifo_din_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: BOOT lasts exactly one cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            BOOT:    state_next_s = RUN;
            RUN:     state_next_s = RUN;
            default: state_next_s = BOOT;
        endcase
    end

    // FSM outputs.
    always_comb begin
        run_s = 1'b0;
        case (state_r)
            RUN:     run_s = 1'b1;
            default: run_s = 1'b0;
        endcase
    end

    // Request credit and handshake qualification; a head leaving this cycle frees its slot.
    always_comb begin
        pop_s       = !fifo_empty_s && id_ready;
        used_s      = {1'b0, fifo_count_s} + {{CW{1'b0}}, outstanding_r};
        limit_s     = DEPTH_W + {{CW{1'b0}}, pop_s};
        req_s       = run_s && !redirect_valid && (used_s < limit_s);
        granted_s   = req_s && imem_gnt;
        rvalid_ok_s = imem_rvalid && outstanding_r;
        push_s      = rvalid_ok_s && !discard_r && !redirect_valid
                      && (!fifo_full_s || pop_s);
    end

    // Next fetch PC, outstanding tracking and discard marking.
    always_comb begin
        pc_next_s     = fetch_pc_r;
        req_pc_next_s = req_pc_r;
        out_next_s    = outstanding_r;
        disc_next_s   = discard_r;
        if (granted_s) begin
            out_next_s    = 1'b1;
            req_pc_next_s = fetch_pc_r;
        end else if (rvalid_ok_s) begin
            out_next_s    = 1'b0;
            req_pc_next_s = req_pc_r;
        end else begin
            out_next_s    = outstanding_r;
            req_pc_next_s = req_pc_r;
        end
        if (redirect_valid) begin
            pc_next_s   = align_pc(redirect_pc);
            disc_next_s = out_next_s;
        end else if (granted_s) begin
            pc_next_s   = fetch_pc_r + 32'd4;
            disc_next_s = rvalid_ok_s ? 1'b0 : discard_r;
        end else begin
            pc_next_s   = fetch_pc_r;
            disc_next_s = rvalid_ok_s ? 1'b0 : discard_r;
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r    <= RESET_PC;
            req_pc_r      <= RESET_PC;
            outstanding_r <= 1'b0;
            discard_r     <= 1'b0;
        end else begin
            fetch_pc_r    <= pc_next_s;
            req_pc_r      <= req_pc_next_s;
            outstanding_r <= out_next_s;
            discard_r     <= disc_next_s;
        end
    end

    assign fifo_din_s = '{inst: imem_rdata, pc: req_pc_r};

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (fifo_din_s),
        .pop   (pop_s),
        .flush (redirect_valid),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s),
        .head  (fifo_head_s)
    );

    assign imem_req  = req_s;
    assign imem_addr = fetch_pc_r;
    assign id_valid  = !fifo_empty_s;
    assign id_inst   = fifo_head_s.inst;
    assign id_pc     = fifo_head_s.pc;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_r;

    // One-cycle flag for a redirect target with nonzero low bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    assign fetch_misalign = misalign_r;
`else
    logic unused_low_bits_s;
    assign unused_low_bits_s = ^redirect_pc[1:0];
    assign fetch_misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based model of
// the fetch stream (sequential PCs between redirects, bounded buffering).
module tb_fetch_queue;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        fetch_misalign;

    always #5 clk = ~clk;

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
        .fetch_misalign(fetch_misalign)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] q[$];
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] exp_fetch = RESET_PC;
    logic        exp_mis = 1'b0;
    logic        boot = 1'b1;
    int          cyc = 0;
    int          first_valid = -1;
    logic [31:0] first_pc = 32'h0;
    int          n_grants = 0;
    int          n_acc = 0;
    logic [31:0] last_grant = 32'h0;
    logic        saw_wrap = 1'b0;
    logic        last_req = 1'b0;
    logic        last_mis = 1'b0;
    logic [31:0] last_addr = 32'h0;
    logic        last_valid = 1'b0;
    int          base;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_0101;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic tick(input logic gnt, input logic rdy, input logic rdv,
                        input logic [31:0] rpc, input logic stray);
        logic exp_req;
        logic pop;
        logic grant;
        int   used;
        @(negedge clk);
        imem_gnt       = gnt;
        id_ready       = rdy;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        imem_rvalid    = pend | stray;
        imem_rdata     = pend ? word_of(pend_addr) : 32'hDEAD_BEEF;
        #1;
        check_eq("id_valid", id_valid, (q.size() != 0));
        check_eq("fetch_misalign", fetch_misalign, exp_mis);
        check_eq("imem_addr", imem_addr, exp_fetch);
        pop     = (q.size() != 0) && rdy;
        used    = q.size() + (pend ? 1 : 0) - (pop ? 1 : 0);
        exp_req = !boot && !rdv && (used < DEPTH);
        check_eq("imem_req", imem_req, exp_req);
        grant   = exp_req && gnt;
        last_req = imem_req; last_mis = fetch_misalign;
        last_addr = imem_addr; last_valid = id_valid;
        if (id_valid && first_valid < 0) begin
            first_valid = cyc;
            first_pc    = id_pc;
        end
        if (pop) begin
            check_eq("id_pc", id_pc, q[0]);
            check_eq("id_inst", id_inst, word_of(q[0]));
            q.delete(0);
            n_acc++;
        end
        if (pend && !rdv) q.push_back(pend_addr);
        if (grant) begin
            if (exp_fetch == 32'h0 && last_grant == 32'hFFFF_FFFC) saw_wrap = 1'b1;
            last_grant = exp_fetch;
            n_grants++;
        end
        pend      = grant;
        pend_addr = exp_fetch;
        if (rdv) begin
            q.delete();
            exp_fetch = {rpc[31:2], 2'b00};
        end else if (grant) begin
            exp_fetch = exp_fetch + 32'd4;
        end
        exp_mis = MIS_EN && rdv && (rpc[1:0] != 2'b00);
        boot = 1'b0;
        cyc++;
    endtask

    // Asynchronous reset assertion mid-cycle; released just after a rising edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
        #1;
        check_eq("rst_imem_req", imem_req, 1'b0);
        check_eq("rst_imem_addr", imem_addr, RESET_PC);
        check_eq("rst_id_valid", id_valid, 1'b0);
        check_eq("rst_id_inst", id_inst, NOP);
        check_eq("rst_id_pc", id_pc, 32'h0);
        check_eq("rst_misalign", fetch_misalign, 1'b0);
        q.delete();
        pend = 1'b0; exp_fetch = RESET_PC; exp_mis = 1'b0; boot = 1'b1;
        last_grant = 32'h0; cyc = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Boot: first id_valid three cycles after BOOT, then one per cycle.
        first_valid = -1; n_acc = 0;
        repeat (12) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("boot_first_valid_cycle", first_valid, 3);
        check_eq("boot_first_pc", first_pc, RESET_PC);
        check_eq("steady_throughput", n_acc, 9);

        // Backpressure: only DEPTH requests while decode stalls.
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        n_grants = 0;
        repeat (10) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("stall_grants", n_grants, DEPTH);
        check_eq("stall_req_low", last_req, 1'b0);
        repeat (10) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect with a response in flight: old word dropped, target in 3 cycles.
        tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("pre_redirect_grant", pend, 1'b1);
        base = cyc;
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
        first_valid = -1;
        repeat (5) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("redirect_latency", first_valid - base, 3);
        check_eq("redirect_first_pc", first_pc, 32'h0000_0100);

        // No grants: address held, nothing delivered, stray rvalid ignored.
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0, (i == 2));
            check_eq("nogrant_addr", last_addr, 32'h0000_0300);
            check_eq("nogrant_valid", last_valid, 1'b0);
        end
        repeat (6) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // PC wrap at the top of the address space.
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0);
        saw_wrap = 1'b0;
        repeat (8) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("pc_wrap", saw_wrap, 1'b1);

        // Misaligned redirect target.
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0102, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("misalign_pulse", last_mis, MIS_EN);
        check_eq("misalign_addr", last_addr, 32'h0000_0100);
        tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("misalign_clear", last_mis, 1'b0);

        // Random traffic.
        repeat (3000) begin
            tick(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 29) == 0), $urandom,
                 (!pend && ($urandom_range(0, 19) == 0)));
        end

        // Reset mid-operation; the late response must be ignored.
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (400) begin
            tick(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 39) == 0), $urandom, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
